// File: rtl/clock_time_core.sv
// clock_time_core: timekeeping stage of the digital clock.
// Divides clk_1khz to a 1 Hz tick, keeps BCD HH:MM:SS (24 h) and packs it
// as {hour_t, hour_u, min_t, min_u, sec_t, sec_u} for the 7-segment driver.
// key_mode cycles RUN -> SET_H -> SET_M -> SET_S -> RUN; key_inc bumps the
// selected field without carry.
// Optional feature: define CLOCK_KEY_DEBOUNCE_EN to add a per-key debouncer
// (DB_CYCLES stable samples) between the synchroniser and the edge detector.
//
// Handshake note: there is no valid/ready traffic here; key presses become
// one-cycle internal strobes and sec_tick is a one-cycle output pulse that
// coincides with the cycle data_out shows the advanced time.
module clock_time_core #(
    parameter int TICK_DIV  = 1000,
    parameter int DB_CYCLES = 20
) (
    input  logic        clk_1khz,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] data_out,
    output logic [1:0]  set_mode,
    output logic        sec_tick
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

    // Bit 0 is the mode key, bit 1 the increment key (both active-low).
    logic [1:0] key_s1, key_s2, key_lvl, key_prev, press;
    logic       mode_ev, inc_ev, tick;
    mode_t      state;
    logic [PW-1:0] pcnt;
    logic [7:0] hour_r, min_r, sec_r, h_nx;
    logic [8:0] m_nx, s_nx;

    // Two-flop synchroniser for both asynchronous keys, idle level high.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
        end else begin
            key_s1 <= {key_inc, key_mode};
            key_s2 <= key_s1;
        end
    end

`ifdef CLOCK_KEY_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES + 1);
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    db_lvl;

    // Debouncer: flip the accepted level only after DB_CYCLES differing samples.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db_lvl[i] <= ~db_lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign key_lvl = db_lvl;
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;
    assign key_lvl   = key_s2;
`endif

    // Previous conditioned level, used to spot the 1 -> 0 (press) transition.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) key_prev <= 2'b11;
        else        key_prev <= key_lvl;
    end

    assign press   = key_prev & ~key_lvl;
    assign mode_ev = press[0];
    assign inc_ev  = press[1] & ~press[0];   // mode step wins over increment
    assign tick    = (state == RUN) && (pcnt == P_MAX);

    // Minutes/seconds successor: {carry, bcd}; an illegal value restarts at 00.
    function automatic logic [8:0] inc_60(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 9'h000;
        if (v[3:0] != 4'd9) return {1'b0, v[7:4], v[3:0] + 4'd1};
        if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
        return 9'h100;
    endfunction

    // Hours successor in 24 h format; an illegal value restarts at 00.
    function automatic logic [7:0] inc_24(input logic [7:0] v);
        if (v[7:4] > 4'd2 || v[3:0] > 4'd9) return 8'h00;
        if (v[7:4] == 4'd2 && v[3:0] > 4'd3) return 8'h00;
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign s_nx = inc_60(sec_r);
    assign m_nx = inc_60(min_r);
    assign h_nx = inc_24(hour_r);

    // Mode FSM, prescaler and time registers; all outputs come from here.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pcnt     <= '0;
            hour_r   <= 8'h00;
            min_r    <= 8'h00;
            sec_r    <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            // Prescaler rests at 0 in SET states and restarts when leaving RUN.
            if (state != RUN || mode_ev || tick) pcnt <= '0;
            else                                 pcnt <= pcnt + PW'(1);

            if (tick) begin
                sec_r <= s_nx[7:0];
                if (s_nx[8]) min_r <= m_nx[7:0];
                if (s_nx[8] && m_nx[8]) hour_r <= h_nx;
            end

            if (mode_ev) begin
                case (state)
                    RUN:     state <= SET_H;
                    SET_H:   state <= SET_M;
                    SET_M:   state <= SET_S;
                    default: state <= RUN;
                endcase
            end else if (inc_ev) begin
                case (state)
                    SET_H:   hour_r <= h_nx;
                    SET_M:   min_r  <= m_nx[7:0];
                    SET_S:   sec_r  <= s_nx[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign data_out = {hour_r, min_r, sec_r};
    assign set_mode = state;

endmodule
